// File: rtl/tx_msg_pkg.sv
// Shared types and constants for the UART status-message scheduler.
// Holds the FSM state encoding, the one-hot memory mode codes and the priority helper.
package tx_msg_pkg;

    localparam int MSG_LEN_DEF = 35;
    localparam int TIMEOUT_DEF = 50000;
    localparam int SETTLE_DEF  = 1;

    localparam logic [2:0] MODE_START_CONTROL = 3'b100;
    localparam logic [2:0] MODE_INITIAL       = 3'b010;
    localparam logic [2:0] MODE_NORMAL        = 3'b001;
    localparam logic [2:0] MODE_NONE          = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_STEP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SEND   = 3'd4,
        ST_WAIT   = 3'd5,
        ST_FLUSH  = 3'd6,
        ST_END    = 3'd7
    } state_t;

    // Request vector is ordered {start_control, initial, normal}; highest bit wins.
    function automatic logic [2:0] prio_onehot(input logic [2:0] req);
        if (req[2]) begin
            prio_onehot = MODE_START_CONTROL;
        end else if (req[1]) begin
            prio_onehot = MODE_INITIAL;
        end else if (req[0]) begin
            prio_onehot = MODE_NORMAL;
        end else begin
            prio_onehot = MODE_NONE;
        end
    endfunction

endpackage

// File: rtl/tx_msg_scheduler_arbiter.sv
// Pending-request latches with a fixed-priority one-hot grant.
// A request arriving in the grant cycle re-arms its bit, so that message is sent again.
module tx_req_arbiter
    import tx_msg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_req,
    input  logic       i_finish,
    input  logic       i_accept,
    output logic [2:0] o_grant,
    output logic       o_valid
);

    logic [2:0] r_pend;
    logic [2:0] w_clr;

    // Only the bit actually granted is cleared, and only when the FSM takes it.
    always_comb begin
        w_clr = 3'b000;
        if (i_accept) begin
            w_clr = o_grant;
        end else begin
            w_clr = 3'b000;
        end
    end

    // Pending latches: set dominates clear, abort wipes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= 3'b000;
        end else if (i_finish) begin
            r_pend <= 3'b000;
        end else begin
            r_pend <= (r_pend & ~w_clr) | i_req;
        end
    end

    assign o_grant = i_finish ? 3'b000 : prio_onehot(r_pend);
    assign o_valid = |o_grant;

endmodule

// File: rtl/tx_msg_scheduler.sv
// Sequences one status message per grant: mode select, per-byte memory step,
// UART start/done handshake, a final flush step that wraps the memory counter.
module tx_msg_scheduler
    import tx_msg_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int SETTLE  = SETTLE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iREQ_START_CONTROL,
    input  logic       iREQ_INITIAL,
    input  logic       iREQ_NORMAL,
    input  logic       iFINISH,
    input  logic       iUART_BUSY,
    input  logic       iUART_DONE,
    output logic       oTX_START_CONTROL,
    output logic       oTX_INITIAL,
    output logic       oTX_NORMAL,
    output logic       oTX_RATE_STATE,
    output logic       oUART_START,
    output logic [5:0] oBYTE_IDX,
    output logic       oMSG_BUSY,
    output logic       oMSG_DONE,
    output logic       oTIMEOUT_ERR
);

    localparam logic [5:0]  IDX_LAST = 6'(MSG_LEN - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0] SET_LAST = 16'(SETTLE - 1);

    state_t      r_state, w_state;
    logic [2:0]  r_mode, w_mode;
    logic        r_step, w_step;
    logic        r_ustart, w_ustart;
    logic [5:0]  r_idx, w_idx;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic        r_terr, w_terr;
    logic [15:0] r_tcnt, w_tcnt;
    logic [15:0] r_scnt, w_scnt;
    logic        r_tout_seen, w_tout_seen;
    logic        w_accept;
    logic [2:0]  w_grant;
    logic        w_valid;

    tx_req_arbiter u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req    ({iREQ_START_CONTROL, iREQ_INITIAL, iREQ_NORMAL}),
        .i_finish (iFINISH),
        .i_accept (w_accept),
        .o_grant  (w_grant),
        .o_valid  (w_valid)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Next state plus next value of every registered output and counter.
    always_comb begin
        w_state     = r_state;
        w_mode      = r_mode;
        w_step      = 1'b0;
        w_ustart    = 1'b0;
        w_idx       = r_idx;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_terr      = 1'b0;
        w_tcnt      = r_tcnt;
        w_scnt      = r_scnt;
        w_tout_seen = r_tout_seen;
        w_accept    = 1'b0;
        if (iFINISH) begin
            w_state     = ST_IDLE;
            w_mode      = MODE_NONE;
            w_idx       = 6'd0;
            w_busy      = 1'b0;
            w_tcnt      = 16'd0;
            w_scnt      = 16'd0;
            w_tout_seen = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        w_accept    = 1'b1;
                        w_state     = ST_SELECT;
                        w_mode      = w_grant;
                        w_busy      = 1'b1;
                        w_idx       = 6'd0;
                        w_tout_seen = 1'b0;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
                ST_SELECT: begin
                    w_state = ST_STEP;
                    w_step  = 1'b1;
                end
                ST_STEP: begin
                    w_state = ST_SETTLE;
                    w_scnt  = 16'd0;
                end
                ST_SETTLE: begin
                    if (r_scnt >= SET_LAST) begin
                        w_state = ST_SEND;
                    end else begin
                        w_scnt = r_scnt + 16'd1;
                    end
                end
                ST_SEND: begin
                    if (!iUART_BUSY) begin
                        w_ustart = 1'b1;
                        w_tcnt   = 16'd0;
                        w_state  = ST_WAIT;
                    end else begin
                        w_state = ST_SEND;
                    end
                end
                ST_WAIT: begin
                    // A done in the same cycle as expiry still counts as a delivered byte.
                    if (iUART_DONE) begin
                        w_step = 1'b1;
                        if (r_idx == IDX_LAST) begin
                            w_state = ST_FLUSH;
                        end else begin
                            w_idx   = r_idx + 6'd1;
                            w_state = ST_STEP;
                        end
                    end else if (r_tcnt >= TO_LAST) begin
                        w_terr      = 1'b1;
                        w_tout_seen = 1'b1;
                        w_step      = 1'b1;
                        w_state     = ST_FLUSH;
                    end else if (r_tcnt != 16'hFFFF) begin
                        w_tcnt = r_tcnt + 16'd1;
                    end else begin
                        w_tcnt = r_tcnt;
                    end
                end
                ST_FLUSH: begin
                    w_state = ST_END;
                    w_mode  = MODE_NONE;
                    w_busy  = 1'b0;
                    w_idx   = 6'd0;
                    w_done  = ~r_tout_seen;
                end
                ST_END: begin
                    w_state     = ST_IDLE;
                    w_tout_seen = 1'b0;
                end
                default: begin
                    w_state = ST_IDLE;
                    w_mode  = MODE_NONE;
                    w_busy  = 1'b0;
                    w_idx   = 6'd0;
                end
            endcase
        end
    end

    // Registered outputs and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode      <= MODE_NONE;
            r_step      <= 1'b0;
            r_ustart    <= 1'b0;
            r_idx       <= 6'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_terr      <= 1'b0;
            r_tcnt      <= 16'd0;
            r_scnt      <= 16'd0;
            r_tout_seen <= 1'b0;
        end else begin
            r_mode      <= w_mode;
            r_step      <= w_step;
            r_ustart    <= w_ustart;
            r_idx       <= w_idx;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_terr      <= w_terr;
            r_tcnt      <= w_tcnt;
            r_scnt      <= w_scnt;
            r_tout_seen <= w_tout_seen;
        end
    end

    assign oTX_START_CONTROL = r_mode[2];
    assign oTX_INITIAL       = r_mode[1];
    assign oTX_NORMAL        = r_mode[0];
    assign oTX_RATE_STATE    = r_step;
    assign oUART_START       = r_ustart;
    assign oBYTE_IDX         = r_idx;
    assign oMSG_BUSY         = r_busy;
    assign oMSG_DONE         = r_done;
    assign oTIMEOUT_ERR      = r_terr;

endmodule

// File: doc/tx_msg_scheduler.md
Name: tx_msg_scheduler

Overview:
- Sequences the UART status-message memory (ASCII "current state:<mode> rate:<r>\n", 35 bytes per message).
- Arbitrates three message requesters: start-control, initial and normal.
- Drives the memory's one-hot mode selects and its per-byte step strobe, then hands each byte to the UART transmitter with a start/done handshake.
- Sits between the system-state FSM and the UART TX core; also handles abort and UART timeout.

Parameters:
- MSG_LEN, 35, bytes per message; the memory emits bytes 0..MSG_LEN-1 and the next step wraps its counter.
- TIMEOUT, 50000, max clk cycles to wait for iUART_DONE after oUART_START before aborting.
- SETTLE, 1, idle cycles between a step pulse and oUART_START, so memory output is stable (minimum 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- iREQ_START_CONTROL  in  1  request for a start-control message; one-cycle pulse or level.
- iREQ_INITIAL  in  1  request for an initial-state message.
- iREQ_NORMAL  in  1  request for a normal-state message.
- iFINISH  in  1  synchronous abort; also blocks new grants while high.
- iUART_BUSY  in  1  UART TX shifting a byte.
- iUART_DONE  in  1  one-cycle pulse at the end of a byte's stop bit.
- oTX_START_CONTROL  out  1  memory mode select; at most one oTX_* mode output high.
- oTX_INITIAL  out  1  memory mode select.
- oTX_NORMAL  out  1  memory mode select.
- oTX_RATE_STATE  out  1  one-cycle step strobe to the memory.
- oUART_START  out  1  one-cycle pulse: load the memory byte into the UART.
- oBYTE_IDX  out  6  index of the byte in flight.
- oMSG_BUSY  out  1  high from grant until return to IDLE.
- oMSG_DONE  out  1  one-cycle pulse after a full message including the flush step.
- oTIMEOUT_ERR  out  1  one-cycle pulse on a UART timeout.

Behaviour:
- Reset (async, active-high): every output 0, all pending bits 0, FSM in IDLE, byte and timeout counters 0.
- Pending latches:
  - One bit per requester, set on any clk edge where its request is high.
  - Cleared on grant; a set in the grant cycle dominates the clear, so the message repeats.
  - All bits cleared while iFINISH is high.
- Arbitration: fixed priority START_CONTROL > INITIAL > NORMAL, evaluated only in IDLE with iFINISH low. No preemption of a message in flight.
- FSM states:
  - IDLE: on any pending bit, go to SELECT; the granted oTX_* and oMSG_BUSY are registered high on the same edge.
  - SELECT: 1 cycle of mode setup, then STEP.
  - STEP: oTX_RATE_STATE high for exactly 1 cycle, then SETTLE.
  - SETTLE: SETTLE cycles, then SEND.
  - SEND: wait for iUART_BUSY low, then pulse oUART_START for 1 cycle, clear the timeout counter, go to WAIT.
  - WAIT:
    - On iUART_DONE: if oBYTE_IDX == MSG_LEN-1, go to FLUSH; else increment oBYTE_IDX and go to STEP.
    - If the timeout counter reaches TIMEOUT: pulse oTIMEOUT_ERR, then go to FLUSH.
  - FLUSH: one extra oTX_RATE_STATE pulse with the mode still held, so the memory counter wraps to 0; then END.
  - END:
    - Drop the mode output, oMSG_BUSY and oBYTE_IDX to 0.
    - Pulse oMSG_DONE only if no timeout occurred.
    - Go to IDLE.
- Latency: with SETTLE=1 and iUART_BUSY low, first oUART_START occurs 4 edges after the IDLE grant edge (SELECT, STEP, SETTLE, SEND).
- Step/start spacing: oTX_RATE_STATE and oUART_START never assert in the same cycle. At most one step per byte, plus exactly one flush step per message.
- iFINISH:
  - In any non-IDLE state, next edge goes to IDLE.
  - All outputs 0, counters cleared; no oMSG_DONE, no flush step (the memory self-clears on iFINISH).
- iUART_DONE outside WAIT is ignored.
- oBYTE_IDX is 6-bit, range 0..MSG_LEN-1, and never exceeds MSG_LEN-1.
- Timeout counter is 16-bit, saturating.

Decomposition:
- Package tx_msg_pkg:
  - FSM state enum (IDLE, SELECT, STEP, SETTLE, SEND, WAIT, FLUSH, END).
  - Mode one-hot encoding (START_CONTROL=3'b100, INITIAL=3'b010, NORMAL=3'b001).
  - MSG_LEN and TIMEOUT defaults.
- Sub-module tx_req_arbiter: pending latches plus fixed-priority grant. Outputs a one-hot grant and a valid; takes a grant-accept input from the FSM.

Test Plan:
- Reset released, iREQ_INITIAL pulsed 1 cycle, UART model returns done 10 cycles after start:
  - exactly 35 oUART_START and 36 oTX_RATE_STATE pulses;
  - oTX_INITIAL high throughout;
  - oMSG_DONE pulses once;
  - oBYTE_IDX runs 0..34.
- iREQ_NORMAL and iREQ_START_CONTROL pulsed in the same cycle: start-control message fully sent first, then normal; oTX_* never overlap.
- iREQ_INITIAL pulsed during byte 12 of a NORMAL message: normal completes uninterrupted, then one initial message follows.
- iFINISH asserted in WAIT at byte 20:
  - next edge all outputs 0, no oMSG_DONE;
  - a later iREQ_NORMAL starts again at oBYTE_IDX 0.
- UART never asserts done with TIMEOUT=100:
  - oTIMEOUT_ERR pulses 100 cycles after the first oUART_START;
  - one flush step follows, no oMSG_DONE, FSM returns to IDLE.
- reset asserted mid-SETTLE: outputs 0 asynchronously, before the next clk edge; pending bits cleared.
